frame_scheduler: RTL and testbench
==================================

// Module: frame_scheduler
// PURPOSE
//   Frame-level sequencer between pixel_iterator and the RGB sources in top.
//   On each frame boundary (vs assertion edge) it issues a single game-update request to the game logic.
//   It times the update against a cycle budget that fits in vertical blanking, and flags overruns.
//   It also latches the pixel-source select at frame boundaries, so the RGB mux never switches mid-frame.
// PARAMETERS
//   VS_ACTIVE      1'b1   level of vs that marks sync (frame edge = transition into this level)
//   TIMEOUT_CYCLES 30000  max clk_rgb cycles (ce high) allowed between upd_start and upd_done
//   FRAME_W        16     width of frame_cnt
//   SRC_W          4      width of source-select code
// PORTS
//   clk_rgb      in   1        pixel clock (only clock)
//   rst_n        in   1        synchronous reset, active low
//   ce           in   1        clock enable (PLL lock); when 0 FSM/counters hold
//   vs           in   1        vertical sync from pixel_iterator
//   src_sel_in   in   SRC_W    raw source request (switches), asynchronous
//   upd_done     in   1        game logic finished update (1-cycle pulse or level)
//   upd_start    out  1        1-cycle pulse: begin game update for next frame
//   upd_busy     out  1        high from upd_start until done/timeout
//   src_sel      out  SRC_W    source select for RGB mux, frame-stable
//   frame_cnt    out  FRAME_W  frames seen since reset, wraps
//   overrun      out  1        sticky: update timed out or crossed a frame edge
//   skip_cnt     out  8        frames whose update was dropped, saturates at 255
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): all outputs 0, FSM=IDLE, timers 0, synchronizer flops 0, vs_q=~VS_ACTIVE.
//   src_sel_in passes a 2-flop synchronizer that runs regardless of ce. All other logic advances only when ce=1.
//   frame_edge = ce & (vs==VS_ACTIVE) & (vs_q!=VS_ACTIVE). vs_q is registered only when ce=1.
//   At frame_edge:
//     - frame_cnt += 1, modulo 2^FRAME_W.
//     - src_sel <= synchronized src_sel_in. This is the only point where src_sel changes.
//   FSM:
//     IDLE:  on frame_edge -> START.
//     START: upd_start=1 for exactly this cycle; upd_busy=1; timer<=0; -> WAIT.
//     WAIT:  upd_busy=1; timer increments each ce cycle.
//            - upd_done=1 -> IDLE; upd_busy drops the next cycle.
//            - timer reaches TIMEOUT_CYCLES-1 without done -> overrun<=1, skip_cnt+1, -> IDLE.
//            - frame_edge without done -> overrun<=1, skip_cnt+1, -> START. This restarts the update for the new frame.
//            - If done and frame_edge occur in the same cycle, done wins: no overrun, -> START.
//            - If done and timeout occur in the same cycle, done wins.
//   upd_done is ignored outside WAIT, including during START.
//   Latency: upd_start is asserted 1 cycle after the frame_edge cycle.
//   overrun clears only on reset. skip_cnt saturates at 8'hFF.
//   ce=0 in any state: state, timer, frame_cnt, src_sel and vs_q hold. upd_start is forced 0 and resumes when ce returns.
//   Reset mid-update (WAIT): returns to IDLE with no upd_start; the pending update is abandoned without an overrun.
// TESTING
//   1. Reset, ce=1, drive 3 vs pulses with upd_done 100 cycles after each upd_start.
//      -> frame_cnt=3, 3 single-cycle upd_start pulses, each 1 cycle after an edge, overrun=0.
//   2. Toggle src_sel_in 0->1 mid-frame.
//      -> src_sel stays 0 until the next frame_edge, then becomes 1. It never changes between edges.
//   3. Withhold upd_done with TIMEOUT_CYCLES=50.
//      -> upd_busy high for exactly 51 cycles incl. START, overrun=1, skip_cnt=1, FSM IDLE.
//   4. TIMEOUT large, withhold upd_done across 2 frame edges.
//      -> upd_start re-issued at each edge, skip_cnt=2, overrun=1.
//   5. Assert upd_done in the same cycle as frame_edge while in WAIT.
//      -> no overrun, upd_start the next cycle. Separately, done at the timeout cycle -> no overrun.
//   6. Drop ce for 20 cycles mid-WAIT, then pulse rst_n=0 during WAIT.
//      -> timer/frame_cnt frozen while ce=0. After reset all outputs 0, FSM IDLE.
//   7. Run frame_cnt with FRAME_W=4 for 17 edges.
//      -> frame_cnt wraps 15->0, reads 1.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler: frame-level sequencer between pixel_iterator and the RGB
// sources. On each frame edge (vs entering VS_ACTIVE) it issues one
// game-update request and times it against TIMEOUT_CYCLES. An update that
// times out or is still pending at the next frame edge is flagged as an
// overrun. It also re-latches the RGB source select only at frame edges.
//
// Ports:
//   clk_rgb    in   pixel clock (only clock)
//   rst_n      in   synchronous reset, active low
//   ce         in   clock enable; when low, FSM, counters and vs history hold
//   vs         in   vertical sync
//   src_sel_in in   raw (asynchronous) source request
//   upd_done   in   game logic finished the update (only observed in WAIT)
//   upd_start  out  1-cycle pulse, one cycle after the frame edge
//   upd_busy   out  high from upd_start until done or timeout
//   src_sel    out  frame-stable source select
//   frame_cnt  out  frames seen since reset (wraps)
//   overrun    out  sticky update-overrun flag
//   skip_cnt   out  dropped updates, saturating at 255
module frame_scheduler #(
  parameter logic        VS_ACTIVE      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 30000,
  parameter int unsigned FRAME_W        = 16,
  parameter int unsigned SRC_W          = 4
) (
  input  logic               clk_rgb,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               vs,
  input  logic [SRC_W-1:0]   src_sel_in,
  input  logic               upd_done,
  output logic               upd_start,
  output logic               upd_busy,
  output logic [SRC_W-1:0]   src_sel,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               overrun,
  output logic [7:0]         skip_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t             state_q,     state_d;
  logic [TMR_W-1:0]   timer_q,     timer_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [SRC_W-1:0]   src_sel_q,   src_sel_d;
  logic [SRC_W-1:0]   sync1_q,     sync1_d;
  logic [SRC_W-1:0]   sync2_q,     sync2_d;
  logic               overrun_q,   overrun_d;
  logic [7:0]         skip_cnt_q,  skip_cnt_d;
  logic               vs_q,        vs_d;
  logic               frame_edge;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    frame_cnt_d = frame_cnt_q;
    src_sel_d   = src_sel_q;
    overrun_d   = overrun_q;
    skip_cnt_d  = skip_cnt_q;
    vs_d        = vs_q;
    // synchronizer is free-running, independent of ce
    sync1_d     = src_sel_in;
    sync2_d     = sync1_q;

    frame_edge = ce && (vs == VS_ACTIVE) && (vs_q != VS_ACTIVE);

    if (ce) begin
      vs_d = vs;
    end

    if (frame_edge) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      src_sel_d   = sync2_q;
    end

    if (ce) begin
      unique case (state_q)
        S_IDLE: begin
          if (frame_edge) state_d = S_START;
        end
        S_START: begin
          timer_d = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // done has priority over both a frame edge and the timeout
          if (upd_done) begin
            state_d = frame_edge ? S_START : S_IDLE;
          end else if (frame_edge) begin
            overrun_d = 1'b1;
            if (skip_cnt_q != 8'hFF) skip_cnt_d = skip_cnt_q + 8'd1;
            state_d = S_START;
          end else if (timer_q == TMR_LAST) begin
            overrun_d = 1'b1;
            if (skip_cnt_q != 8'hFF) skip_cnt_d = skip_cnt_q + 8'd1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rgb) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      frame_cnt_q <= '0;
      src_sel_q   <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      overrun_q   <= 1'b0;
      skip_cnt_q  <= '0;
      vs_q        <= ~VS_ACTIVE;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      frame_cnt_q <= frame_cnt_d;
      src_sel_q   <= src_sel_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      overrun_q   <= overrun_d;
      skip_cnt_q  <= skip_cnt_d;
      vs_q        <= vs_d;
    end
  end

  // START is held while ce is low, but the pulse is suppressed until ce returns
  assign upd_start = ce && (state_q == S_START);
  assign upd_busy  = (state_q != S_IDLE);
  assign src_sel   = src_sel_q;
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;
  assign skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Testbench for frame_scheduler: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// behavioural model of the frame/update rules.
module tb_frame_scheduler;

  localparam int TO   = 50;
  localparam int FW   = 4;
  localparam int SW   = 4;
  localparam int FMOD = 1 << FW;

  logic          clk_rgb = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b1;
  logic          vs = 1'b0;
  logic [SW-1:0] src_sel_in = '0;
  logic          upd_done = 1'b0;
  logic          upd_start;
  logic          upd_busy;
  logic [SW-1:0] src_sel;
  logic [FW-1:0] frame_cnt;
  logic          overrun;
  logic [7:0]    skip_cnt;

  frame_scheduler #(
    .VS_ACTIVE      (1'b1),
    .TIMEOUT_CYCLES (TO),
    .FRAME_W        (FW),
    .SRC_W          (SW)
  ) dut (
    .clk_rgb    (clk_rgb),
    .rst_n      (rst_n),
    .ce         (ce),
    .vs         (vs),
    .src_sel_in (src_sel_in),
    .upd_done   (upd_done),
    .upd_start  (upd_start),
    .upd_busy   (upd_busy),
    .src_sel    (src_sel),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun),
    .skip_cnt   (skip_cnt)
  );

  initial forever #5 clk_rgb = ~clk_rgb;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_ok = 0;
  bit m_vs_prev;
  int m_frame, m_sel, m_s1, m_s2, m_waited, m_skip;
  bit m_busy, m_start, m_ovr;

  task automatic m_drop();
    m_ovr = 1;
    if (m_skip < 255) m_skip++;
  endtask

  always @(posedge clk_rgb) begin
    int old_s2;
    bit fe;
    if (!rst_n) begin
      m_ok = 1; m_vs_prev = 0; m_frame = 0; m_sel = 0; m_s1 = 0; m_s2 = 0;
      m_waited = 0; m_skip = 0; m_busy = 0; m_start = 0; m_ovr = 0;
    end else begin
      old_s2 = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(src_sel_in);
      if (ce) begin
        fe = vs && !m_vs_prev;
        m_vs_prev = vs;
        if (fe) begin
          m_frame = (m_frame + 1) % FMOD;
          m_sel = old_s2;
        end
        if (m_start) begin
          m_start = 0;
          m_waited = 0;
        end else if (m_busy) begin
          if (upd_done) begin
            m_busy = fe;
            m_start = fe;
          end else if (fe) begin
            m_drop();
            m_start = 1;
          end else if (m_waited == TO - 1) begin
            m_drop();
            m_busy = 0;
          end else begin
            m_waited++;
          end
        end else if (fe) begin
          m_busy = 1;
          m_start = 1;
        end
      end
    end
  end

  int starts = 0;
  int busy_cyc = 0;

  always @(negedge clk_rgb) begin
    if (m_ok) begin
      chk("upd_start", int'(upd_start), int'(m_start && ce));
      chk("upd_busy",  int'(upd_busy),  int'(m_busy));
      chk("src_sel",   int'(src_sel),   m_sel);
      chk("frame_cnt", int'(frame_cnt), m_frame);
      chk("overrun",   int'(overrun),   int'(m_ovr));
      chk("skip_cnt",  int'(skip_cnt),  m_skip);
      if (upd_start) starts++;
      if (upd_busy) busy_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_rgb);
      #2;
    end
  endtask

  // edge is sampled at the first tick; DUT is in WAIT (timer 0) on return
  task automatic vs_pulse();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
  endtask

  task automatic frame_with_done(input int n);
    vs_pulse();
    tick(n);
    upd_done = 1'b1; tick();
    upd_done = 1'b0; tick(3);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_start"}, int'(upd_start), 0);
    chk({nm, "_busy"},  int'(upd_busy),  0);
    chk({nm, "_sel"},   int'(src_sel),   0);
    chk({nm, "_frame"}, int'(frame_cnt), 0);
    chk({nm, "_ovr"},   int'(overrun),   0);
    chk({nm, "_skip"},  int'(skip_cnt),  0);
  endtask

  initial begin
    int s0, f0, vs_gap;

    // reset
    rst_n = 1'b0; tick(2);
    check_all_zero("reset");
    rst_n = 1'b1; tick(3);

    // three frames, done 20 cycles into each update
    starts = 0;
    for (int i = 0; i < 3; i++) frame_with_done(20);
    chk("t1_frame", int'(frame_cnt), 3);
    chk("t1_starts", starts, 3);
    chk("t1_ovr", int'(overrun), 0);

    // source select only moves at a frame edge
    src_sel_in = 4'd1; tick(10);
    chk("t2_sel_hold", int'(src_sel), 0);
    vs = 1'b1; tick();
    chk("t2_sel_edge", int'(src_sel), 1);
    vs = 1'b0; tick(5);
    upd_done = 1'b1; tick(); upd_done = 1'b0; tick(3);

    // timeout: busy 1 START + 50 WAIT cycles
    busy_cyc = 0;
    vs_pulse(); tick(70);
    chk("t3_busy_cycles", busy_cyc, 51);
    chk("t3_ovr", int'(overrun), 1);
    chk("t3_skip", int'(skip_cnt), 1);
    chk("t3_idle", int'(upd_busy), 0);

    // two frame edges during a pending update
    starts = 0;
    vs_pulse(); tick(10);
    vs_pulse(); tick(10);
    vs_pulse(); tick(4);
    upd_done = 1'b1; tick(); upd_done = 1'b0; tick(3);
    chk("t4_starts", starts, 3);
    chk("t4_skip", int'(skip_cnt), 3);

    // done coincides with frame edge
    vs_pulse(); tick(5);
    vs = 1'b1; upd_done = 1'b1; tick();
    chk("t5_restart", int'(upd_start), 1);
    vs = 1'b0; upd_done = 1'b0; tick(2);
    upd_done = 1'b1; tick(); upd_done = 1'b0; tick(3);
    chk("t5_skip_edge", int'(skip_cnt), 3);
    // done exactly on the timeout cycle (timer = TO-1)
    vs_pulse(); tick(TO - 1);
    upd_done = 1'b1; tick(); upd_done = 1'b0;
    chk("t5_idle_to", int'(upd_busy), 0);
    tick(3);
    chk("t5_skip_to", int'(skip_cnt), 3);

    // ce low mid-WAIT, then reset during WAIT
    vs_pulse(); tick(5);
    f0 = int'(frame_cnt);
    ce = 1'b0;
    tick(8); vs = 1'b1; tick(2); vs = 1'b0; tick(10);
    chk("t6_frame_frozen", int'(frame_cnt), f0);
    chk("t6_busy_held", int'(upd_busy), 1);
    ce = 1'b1; tick(10);
    chk("t6_busy_still", int'(upd_busy), 1);
    rst_n = 1'b0; tick();
    check_all_zero("t6_reset");
    rst_n = 1'b1; src_sel_in = '0; tick(3);

    // 17 frames wrap the 4-bit frame counter
    s0 = starts;
    for (int i = 0; i < 17; i++) frame_with_done(3);
    chk("t7_wrap", int'(frame_cnt), 1);
    chk("t7_starts", starts - s0, 17);
    chk("t7_ovr", int'(overrun), 0);

    // randomized traffic against the model
    vs_gap = 10;
    for (int i = 0; i < 5000; i++) begin
      ce = ($urandom_range(0, 9) != 0);
      if (vs_gap == 0) begin
        vs = 1'b1;
        vs_gap = $urandom_range(3, 75);
      end else begin
        vs = ($urandom_range(0, 7) == 0) ? vs : 1'b0;
        vs_gap--;
      end
      upd_done = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) src_sel_in = SW'($urandom);
      rst_n = ($urandom_range(0, 1499) != 0);
      tick();
    end
    rst_n = 1'b1; ce = 1'b1; vs = 1'b0; upd_done = 1'b0;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
